keypad_entry_ctrl: RTL and testbench

- Sequences keypad entry for the alarm clock.
- Captures BCD digits from the 4-bit keypad, counting each press once, into a 4-digit HH:MM buffer.
- Validates the buffer and issues one-cycle load strobes to the time counter or the alarm register when time_button or alarm_button is pressed.
- Sits between the keypad/buttons and the clock datapath, and drives the display-select signal for the entry view.

---
 rtl/alarm_clk_pkg.sv | 20 ++
 rtl/bcd_time_check.sv | 27 ++
 rtl/keypad_entry_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clk_pkg.sv
// Shared alarm-clock definitions: keypad codes, entry states and BCD time limits.
package alarm_clk_pkg;

  localparam logic [3:0] NOKEY           = 4'd10;
  localparam logic [3:0] MAX_BCD_DIGIT   = 4'd9;
  localparam logic [3:0] MAX_MS_HR       = 4'd2;
  localparam logic [3:0] MAX_LS_HR_AT_20 = 4'd3;
  localparam logic [3:0] MAX_MS_MIN      = 4'd5;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    KEY_STORED = 2'd1,
    KEY_WAIT   = 2'd2
  } entry_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= MAX_BCD_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_time_check.sv
// Combinational HH:MM BCD validity check, shared by keypad entry and alarm register.
module bcd_time_check
  import alarm_clk_pkg::*;
(
  input  logic [15:0] bcd_time,
  output logic        valid
);

  logic [3:0] ms_hr_s;
  logic [3:0] ls_hr_s;
  logic [3:0] ms_min_s;
  logic [3:0] ls_min_s;
  logic       hr_ok_s;
  logic       min_ok_s;

  assign ms_hr_s  = bcd_time[15:12];
  assign ls_hr_s  = bcd_time[11:8];
  assign ms_min_s = bcd_time[7:4];
  assign ls_min_s = bcd_time[3:0];

  // Hours above 19 only allow 20-23.
  assign hr_ok_s  = (ms_hr_s <= MAX_MS_HR) && (ls_hr_s <= MAX_BCD_DIGIT) &&
                    ((ms_hr_s != MAX_MS_HR) || (ls_hr_s <= MAX_LS_HR_AT_20));
  assign min_ok_s = (ms_min_s <= MAX_MS_MIN) && (ls_min_s <= MAX_BCD_DIGIT);
  assign valid    = hr_ok_s && min_ok_s;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: collects HH:MM digits, validates them and strobes
// the time counter or alarm register on a button edge.
module keypad_entry_ctrl
  import alarm_clk_pkg::*;
#(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        one_second,
  input  logic [3:0]  key,
  input  logic        time_button,
  input  logic        alarm_button,
  output logic [15:0] new_time,
  output logic        load_new_time,
  output logic        load_new_alarm,
  output logic        show_keyboard,
  output logic        entry_error,
  output logic [2:0]  digit_count
);

  localparam int TW = $clog2(TIMEOUT_SEC + 1);

  entry_state_e  state_r;
  entry_state_e  state_nxt_s;
  logic [15:0]   new_time_r;
  logic [15:0]   new_time_nxt_s;
  logic [2:0]    digit_count_r;
  logic [2:0]    digit_count_nxt_s;
  logic          load_time_r;
  logic          load_time_nxt_s;
  logic          load_alarm_r;
  logic          load_alarm_nxt_s;
  logic          error_r;
  logic          error_nxt_s;
  logic          show_r;
  logic          show_nxt_s;
  logic [TW-1:0] tmo_r;
  logic [TW-1:0] tmo_nxt_s;
  logic          time_prev_r;
  logic          alarm_prev_r;

  logic          time_edge_s;
  logic          alarm_edge_s;
  logic          digit_s;
  logic          final_tick_s;
  logic          buf_valid_s;
  logic          commit_ok_s;
  logic [2:0]    count_inc_s;

  bcd_time_check u_check (
    .bcd_time (new_time_r),
    .valid    (buf_valid_s)
  );

  assign time_edge_s  = time_button && !time_prev_r;
  assign alarm_edge_s = alarm_button && !alarm_prev_r;
  assign digit_s      = is_digit(key);
  assign final_tick_s = one_second && (tmo_r == TW'(TIMEOUT_SEC - 1));
  assign commit_ok_s  = (digit_count_r == 3'd4) && buf_valid_s;
  assign count_inc_s  = (digit_count_r == 3'd4) ? 3'd4 : (digit_count_r + 3'd1);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, buffer, counter and strobe decode.
  always_comb begin
    state_nxt_s       = state_r;
    new_time_nxt_s    = new_time_r;
    digit_count_nxt_s = digit_count_r;
    load_time_nxt_s   = 1'b0;
    load_alarm_nxt_s  = 1'b0;
    error_nxt_s       = 1'b0;
    tmo_nxt_s         = tmo_r;

    case (state_r)
      IDLE: begin
        if (digit_s) begin
          new_time_nxt_s    = {12'h000, key};
          digit_count_nxt_s = 3'd1;
          tmo_nxt_s         = {TW{1'b0}};
          state_nxt_s       = KEY_STORED;
        end else begin
          tmo_nxt_s = {TW{1'b0}};
        end
      end

      KEY_STORED: begin
        if (final_tick_s) begin
          digit_count_nxt_s = 3'd0;
          tmo_nxt_s         = {TW{1'b0}};
          state_nxt_s       = IDLE;
        end else begin
          if (one_second) begin
            tmo_nxt_s = tmo_r + TW'(1);
          end else begin
            tmo_nxt_s = tmo_r;
          end
          // Any non-digit code counts as a release; a new digit while held is ignored.
          if (!digit_s) begin
            state_nxt_s = KEY_WAIT;
          end else begin
            state_nxt_s = KEY_STORED;
          end
        end
      end

      KEY_WAIT: begin
        if (digit_s) begin
          new_time_nxt_s    = {new_time_r[11:0], key};
          digit_count_nxt_s = count_inc_s;
          tmo_nxt_s         = {TW{1'b0}};
          state_nxt_s       = KEY_STORED;
        end else if (time_edge_s || alarm_edge_s) begin
          // Time wins over a simultaneous alarm edge, which is then dropped.
          if (time_edge_s) begin
            load_time_nxt_s = commit_ok_s;
          end else begin
            load_alarm_nxt_s = commit_ok_s;
          end
          error_nxt_s       = !commit_ok_s;
          digit_count_nxt_s = 3'd0;
          tmo_nxt_s         = {TW{1'b0}};
          state_nxt_s       = IDLE;
        end else if (final_tick_s) begin
          digit_count_nxt_s = 3'd0;
          tmo_nxt_s         = {TW{1'b0}};
          state_nxt_s       = IDLE;
        end else if (one_second) begin
          tmo_nxt_s = tmo_r + TW'(1);
        end else begin
          tmo_nxt_s = tmo_r;
        end
      end

      default: begin
        digit_count_nxt_s = 3'd0;
        tmo_nxt_s         = {TW{1'b0}};
        state_nxt_s       = IDLE;
      end
    endcase

    show_nxt_s = (state_nxt_s != IDLE);
  end

  // Output, timeout and button-history registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      new_time_r    <= 16'h0000;
      digit_count_r <= 3'd0;
      load_time_r   <= 1'b0;
      load_alarm_r  <= 1'b0;
      error_r       <= 1'b0;
      show_r        <= 1'b0;
      tmo_r         <= {TW{1'b0}};
      time_prev_r   <= 1'b0;
      alarm_prev_r  <= 1'b0;
    end else begin
      new_time_r    <= new_time_nxt_s;
      digit_count_r <= digit_count_nxt_s;
      load_time_r   <= load_time_nxt_s;
      load_alarm_r  <= load_alarm_nxt_s;
      error_r       <= error_nxt_s;
      show_r        <= show_nxt_s;
      tmo_r         <= tmo_nxt_s;
      time_prev_r   <= time_button;
      alarm_prev_r  <= alarm_button;
    end
  end

  assign new_time       = new_time_r;
  assign digit_count    = digit_count_r;
  assign load_new_time  = load_time_r;
  assign load_new_alarm = load_alarm_r;
  assign entry_error    = error_r;
  assign show_keyboard  = show_r;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Randomized and directed bench for keypad_entry_ctrl against a digit-queue reference model.
module tb_keypad_entry_ctrl;

  localparam logic [3:0] NK      = 4'd10;
  localparam int         TIMEOUT = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        one_second = 1'b0;
  logic [3:0]  key = NK;
  logic        time_button = 1'b0;
  logic        alarm_button = 1'b0;
  logic [15:0] new_time;
  logic        load_new_time;
  logic        load_new_alarm;
  logic        show_keyboard;
  logic        entry_error;
  logic [2:0]  digit_count;

  int n_checks = 0;
  int n_errors = 0;

  keypad_entry_ctrl #(.TIMEOUT_SEC(TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .one_second     (one_second),
    .key            (key),
    .time_button    (time_button),
    .alarm_button   (alarm_button),
    .new_time       (new_time),
    .load_new_time  (load_new_time),
    .load_new_alarm (load_new_alarm),
    .show_keyboard  (show_keyboard),
    .entry_error    (entry_error),
    .digit_count    (digit_count)
  );

  always #5 clk = ~clk;

  // Reference model: the digits typed in the current entry, plus entry/hold flags.
  int q[$];
  bit m_active, m_held, m_tprev, m_aprev;
  int m_cnt, m_ticks;
  bit e_lt, e_la, e_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] packed_digits();
    logic [15:0] v = 16'h0000;
    foreach (q[i]) v = {v[11:0], 4'(q[i])};
    return v;
  endfunction

  function automatic bit entry_is_valid_time();
    if (m_cnt != 4 || q.size() != 4) return 1'b0;
    return ((q[0] * 10 + q[1]) <= 23) && ((q[2] * 10 + q[3]) <= 59);
  endfunction

  task automatic model_reset();
    q.delete();
    m_active = 0; m_held = 0; m_tprev = 0; m_aprev = 0;
    m_cnt = 0; m_ticks = 0; e_lt = 0; e_la = 0; e_err = 0;
  endtask

  task automatic model_step(input logic [3:0] k, input logic tb, input logic ab, input logic tk);
    bit te, ae, dig, ok;
    te = tb && !m_tprev;
    ae = ab && !m_aprev;
    m_tprev = tb;
    m_aprev = ab;
    dig = (k <= 4'd9);
    e_lt = 0; e_la = 0; e_err = 0;
    if (!m_active) begin
      if (dig) begin
        q.delete(); q.push_back(int'(k));
        m_cnt = 1; m_active = 1; m_held = 1; m_ticks = 0;
      end
    end else if (!m_held && dig) begin
      q.push_back(int'(k));
      if (q.size() > 4) void'(q.pop_front());
      if (m_cnt < 4) m_cnt++;
      m_held = 1; m_ticks = 0;
    end else if (!m_held && (te || ae)) begin
      ok = entry_is_valid_time();
      if (te) e_lt = ok; else e_la = ok;
      e_err = !ok;
      m_cnt = 0; m_active = 0; m_ticks = 0;
    end else begin
      if (tk) m_ticks++;
      if (m_ticks >= TIMEOUT) begin
        m_active = 0; m_cnt = 0; m_ticks = 0; m_held = 0;
      end else if (m_held && !dig) begin
        m_held = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("new_time", 32'(new_time), 32'(packed_digits()));
    check("digit_count", 32'(digit_count), 32'(m_cnt));
    check("load_new_time", 32'(load_new_time), 32'(e_lt));
    check("load_new_alarm", 32'(load_new_alarm), 32'(e_la));
    check("entry_error", 32'(entry_error), 32'(e_err));
    check("show_keyboard", 32'(show_keyboard), 32'(m_active));
  endtask

  task automatic cyc(input logic [3:0] k, input logic tb, input logic ab, input logic tk);
    @(negedge clk);
    key = k; time_button = tb; alarm_button = ab; one_second = tk;
    model_step(k, tb, ab, tk);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic press(input logic [3:0] d, input int hold);
    repeat (hold) cyc(d, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(NK, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    press(a, 5); press(b, 5); press(c, 5); press(d, 5);
  endtask

  task automatic button(input logic tb, input logic ab);
    cyc(NK, tb, ab, 1'b0);
  endtask

  initial begin
    int hh, mm, act;
    logic [3:0] dg;
    model_reset();
    #2 reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_new_time", 32'(new_time), 32'h0);
    check("rst_digit_count", 32'(digit_count), 32'h0);
    check("rst_show", 32'(show_keyboard), 32'h0);
    check("rst_strobes", {29'h0, load_new_time, load_new_alarm, entry_error}, 32'h0);
    @(negedge clk) reset = 1'b1;

    enter4(4'd2, 4'd1, 4'd2, 4'd3);
    button(1'b1, 1'b0);
    check("t2123_load", 32'(load_new_time), 32'h1);
    check("t2123_value", 32'(new_time), 32'h2123);
    button(1'b0, 1'b0);
    check("t2123_single", 32'(load_new_time), 32'h0);
    check("t2123_show", 32'(show_keyboard), 32'h0);
    check("t2123_count", 32'(digit_count), 32'h0);

    enter4(4'd2, 4'd2, 4'd0, 4'd0);
    button(1'b0, 1'b1);
    check("a2200_load", 32'(load_new_alarm), 32'h1);
    check("a2200_value", 32'(new_time), 32'h2200);
    button(1'b0, 1'b0);

    enter4(4'd2, 4'd5, 4'd0, 4'd0);
    button(1'b1, 1'b0);
    check("t2500_error", 32'(entry_error), 32'h1);
    check("t2500_noload", 32'(load_new_time), 32'h0);
    button(1'b0, 1'b0);

    press(4'd1, 3); press(4'd2, 3);
    button(1'b1, 1'b0);
    check("short_error", 32'(entry_error), 32'h1);
    button(1'b0, 1'b0);

    press(4'd7, 50);
    check("hold7_count", 32'(digit_count), 32'h1);
    check("hold7_value", 32'(new_time), 32'h0007);
    repeat (TIMEOUT) cyc(NK, 1'b0, 1'b0, 1'b1);

    press(4'd1, 2); press(4'd2, 2); press(4'd3, 2); press(4'd4, 2); press(4'd5, 2);
    check("five_value", 32'(new_time), 32'h2345);
    check("five_count", 32'(digit_count), 32'h4);
    button(1'b1, 1'b0);
    button(1'b0, 1'b0);

    press(4'd1, 2); press(4'd2, 2);
    repeat (TIMEOUT - 1) cyc(NK, 1'b0, 1'b0, 1'b1);
    check("tmo_not_yet", 32'(show_keyboard), 32'h1);
    cyc(NK, 1'b0, 1'b0, 1'b1);
    check("tmo_show", 32'(show_keyboard), 32'h0);
    check("tmo_count", 32'(digit_count), 32'h0);

    enter4(4'd1, 4'd2, 4'd3, 4'd0);
    button(1'b1, 1'b1);
    check("both_time", 32'(load_new_time), 32'h1);
    check("both_alarm", 32'(load_new_alarm), 32'h0);
    check("both_error", 32'(entry_error), 32'h0);
    button(1'b0, 1'b0);

    press(4'd1, 2); press(4'd2, 2);
    #3 reset = 1'b0;
    #1;
    check("arst_new_time", 32'(new_time), 32'h0);
    check("arst_count", 32'(digit_count), 32'h0);
    check("arst_show", 32'(show_keyboard), 32'h0);
    model_reset();
    @(negedge clk) reset = 1'b1;

    for (int it = 0; it < 400; it++) begin
      act = $urandom_range(0, 9);
      if (act < 5) begin
        dg = 4'($urandom_range(0, 9));
        for (int h = 0; h < int'($urandom_range(1, 6)); h++) begin
          cyc(($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 9)) : dg, 1'b0, 1'b0, ($urandom_range(0, 5) == 0));
        end
        for (int r = 0; r < int'($urandom_range(1, 3)); r++) begin
          cyc(4'($urandom_range(10, 15)), 1'b0, 1'b0, ($urandom_range(0, 5) == 0));
        end
      end else if (act < 7) begin
        hh = $urandom_range(0, 23);
        mm = $urandom_range(0, 59);
        enter4(4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10));
        button($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        button(1'b0, 1'b0);
      end else if (act < 9) begin
        cyc(NK, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, ($urandom_range(0, 3) == 0));
        cyc(NK, 1'b0, 1'b0, 1'b0);
      end else begin
        repeat ($urandom_range(1, 12)) cyc(NK, 1'b0, 1'b0, ($urandom_range(0, 1) == 1));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
